// File: rtl/shift_arb_seq_if.sv
// Request/response bundle for the shared bit-serial shifter: two requester
// ports plus one result port.
interface shift_arb_seq_if #(
    parameter int WIDTH = 4,
    parameter int SHW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [SHW-1:0]   req0_amt;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [SHW-1:0]   req1_amt;
    logic [1:0]       req1_op;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;

    // Requesters and the result consumer.
    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id
    );

    // The shifter itself.
    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/shift_arb_seq.sv
// Two-requester round-robin arbiter in front of a one-bit-per-cycle shifter
// (LSR/LSL/ASR/ROR) with a valid/ready result port.
module shift_arb_seq #(
    parameter int WIDTH = 4,
    parameter int SHW   = 4,
    parameter int CW    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arb_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_LSL = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam int unsigned WU = WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             ptr_q, ptr_d;
    logic             gnt_vld, gnt_id;

    // Step count: beyond WIDTH steps LSR/LSL/ASR no longer change, ROR wraps.
    function automatic logic [CW-1:0] load_cnt(input logic [1:0] op, input logic [SHW-1:0] amt);
        int unsigned a;
        a = 32'(amt);
        if (op == OP_ROR) return CW'(a % WU);
        if (a >= WU) return CW'(WU);
        return CW'(a);
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [1:0] op, input logic [WIDTH-1:0] w);
        logic signed [WIDTH-1:0] s;
        s = $signed(w);
        case (op)
            OP_LSR:  return {1'b0, w[WIDTH-1:1]};
            OP_LSL:  return {w[WIDTH-2:0], 1'b0};
            OP_ASR:  return $unsigned(s >>> 1);
            default: return {w[0], w[WIDTH-1:1]};
        endcase
    endfunction

    // Lone requester wins; on contention the pointer decides.
    assign gnt_vld = bus.req0_valid | bus.req1_valid;
    assign gnt_id  = bus.req1_valid & (~bus.req0_valid | ptr_q);

    assign bus.req0_ready = rst_n && (state_q == IDLE) && bus.req0_valid && !gnt_id;
    assign bus.req1_ready = rst_n && (state_q == IDLE) && bus.req1_valid && gnt_id;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_data  = work_q;
    assign bus.resp_id    = id_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    id_d    = gnt_id;
                    state_d = SHIFT;
                    if (gnt_id) begin
                        work_d = bus.req1_data;
                        op_d   = bus.req1_op;
                        cnt_d  = load_cnt(bus.req1_op, bus.req1_amt);
                    end else begin
                        work_d = bus.req0_data;
                        op_d   = bus.req0_op;
                        cnt_d  = load_cnt(bus.req0_op, bus.req0_amt);
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    work_d = step(op_q, work_q);
                    cnt_d  = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_LSR;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_shift_arb_seq.sv
// Randomised and directed bench for shift_arb_seq against a transaction-level
// model of arbitration, result value and response latency.
module tb_shift_arb_seq;
    localparam int W = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    shift_arb_seq_if #(.WIDTH(W), .SHW(S)) bus();

    shift_arb_seq #(.WIDTH(W), .SHW(S), .CW(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_shift(input logic [1:0] op, input logic [3:0] d, input logic [3:0] a);
        logic signed [3:0] sd;
        logic [7:0] dd;
        int r;
        case (op)
            2'b00: return d >> a;
            2'b01: return d << a;
            2'b10: begin sd = d; sd = sd >>> a; return sd; end
            default: begin r = int'(a) % 4; dd = {d, d}; return dd[r +: 4]; end
        endcase
    endfunction

    function automatic int ref_steps(input logic [1:0] op, input logic [3:0] a);
        if (op == 2'b11) return int'(a) % 4;
        return (int'(a) >= 4) ? 4 : int'(a);
    endfunction

    bit         m_busy = 0;
    bit         m_ptr  = 0;
    bit         m_id   = 0;
    logic [3:0] m_exp  = '0;
    int         m_cyc  = 0;
    int         m_resp = 0;
    int         grants[$];

    // Reference compare: one observation per clock interval, model advanced
    // as if the following rising edge had happened.
    always @(negedge clk) begin
        bit g0, g1;
        if (!rst_n) begin
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_resp_data", bus.resp_data, 0);
            chk("rst_resp_id", bus.resp_id, 0);
            chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
            m_busy = 0;
            m_ptr  = 0;
            grants.delete();
        end else begin
            if (!m_busy) begin
                g0 = bus.req0_valid && (!bus.req1_valid || m_ptr == 0);
                g1 = bus.req1_valid && (!bus.req0_valid || m_ptr == 1);
                chk("idle_req0_ready", bus.req0_ready, g0);
                chk("idle_req1_ready", bus.req1_ready, g1);
                chk("idle_resp_valid", bus.resp_valid, 0);
                if (g0) begin
                    m_busy = 1; m_id = 0;
                    m_exp  = ref_shift(bus.req0_op, bus.req0_data, bus.req0_amt);
                    m_resp = m_cyc + 2 + ref_steps(bus.req0_op, bus.req0_amt);
                    grants.push_back(0);
                end else if (g1) begin
                    m_busy = 1; m_id = 1;
                    m_exp  = ref_shift(bus.req1_op, bus.req1_data, bus.req1_amt);
                    m_resp = m_cyc + 2 + ref_steps(bus.req1_op, bus.req1_amt);
                    grants.push_back(1);
                end
            end else if (m_cyc < m_resp) begin
                chk("busy_ready", {bus.req1_ready, bus.req0_ready}, 0);
                chk("busy_resp_valid", bus.resp_valid, 0);
            end else begin
                chk("done_ready", {bus.req1_ready, bus.req0_ready}, 0);
                chk("done_resp_valid", bus.resp_valid, 1);
                chk("done_resp_data", bus.resp_data, m_exp);
                chk("done_resp_id", bus.resp_id, m_id);
                if (bus.resp_ready) begin
                    m_busy = 0;
                    m_ptr  = ~m_id;
                end
            end
            m_cyc++;
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_op = '0;
        bus.req1_valid = 0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_op = '0;
        bus.resp_ready = 1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        wait_cycles(2);
        rst_n = 1;
    endtask

    // One request on one port; checks grant, latency in edges after the
    // handshake edge, result and id against hand-supplied values.
    task automatic send(input bit id, input logic [3:0] d, input logic [3:0] a, input logic [1:0] op,
                        input logic [3:0] exp, input int exp_lat, input string name);
        int lat;
        bit got;
        if (id == 0) begin
            bus.req0_data = d; bus.req0_amt = a; bus.req0_op = op; bus.req0_valid = 1;
        end else begin
            bus.req1_data = d; bus.req1_amt = a; bus.req1_op = op; bus.req1_valid = 1;
        end
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
                got = 1;
                break;
            end
        end
        chk({name, "_grant"}, got, 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        lat = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.resp_valid) begin
                got = 1;
                break;
            end
        end
        chk({name, "_resp_seen"}, got, 1);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_data"}, bus.resp_data, exp);
        chk({name, "_id"}, bus.resp_id, id);
    endtask

    initial begin
        logic [3:0] d0;
        bit         i0;
        bit         got;
        logic [3:0] dv, av;

        idle_inputs();
        rst_n = 0;
        #1;
        chk("reset_resp_valid", bus.resp_valid, 0);
        chk("reset_resp_data", bus.resp_data, 0);
        chk("reset_resp_id", bus.resp_id, 0);
        chk("reset_ready", {bus.req1_ready, bus.req0_ready}, 0);
        wait_cycles(3);
        rst_n = 1;
        wait_cycles(2);

        // Hand-computed op coverage.
        send(0, 4'hA, 4'd1, 2'b00, 4'h5, 2, "lsr_a_1");
        send(0, 4'hA, 4'd9, 2'b00, 4'h0, 5, "lsr_a_9");
        send(0, 4'b1000, 4'd2, 2'b10, 4'b1110, 3, "asr_8_2");
        send(0, 4'b0011, 4'd3, 2'b01, 4'b1000, 4, "lsl_3_3");
        send(0, 4'b0001, 4'd5, 2'b11, 4'b1000, 2, "ror_1_5");
        send(0, 4'h9, 4'd7, 2'b10, 4'hF, 5, "asr_9_7");
        send(0, 4'hB, 4'd0, 2'b10, 4'hB, 1, "asr_amt0");
        send(0, 4'h6, 4'd0, 2'b11, 4'h6, 1, "ror_amt0");
        send(0, 4'h5, 4'd0, 2'b01, 4'h5, 1, "lsl_amt0");
        send(1, 4'hC, 4'd2, 2'b00, 4'h3, 3, "lsr_req1");

        // Exhaustive logical-right sweep on requester 0.
        for (int d = 0; d < 16; d++) begin
            for (int a = 0; a < 16; a++) begin
                dv = 4'(d);
                av = 4'(a);
                send(0, dv, av, 2'b00, dv >> av, 1 + ((a >= 4) ? 4 : a), "lsr_sweep");
            end
        end
        wait_cycles(8);

        // Random traffic on both ports with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_data  = 4'($urandom);
            bus.req0_amt   = 4'($urandom);
            bus.req0_op    = 2'($urandom);
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_data  = 4'($urandom);
            bus.req1_amt   = 4'($urandom);
            bus.req1_op    = 2'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            wait_cycles(1);
        end
        idle_inputs();
        wait_cycles(20);

        // Contention from a fresh pointer must alternate starting at 0.
        do_reset();
        bus.req0_data = 4'h3; bus.req0_amt = 4'd0; bus.req0_op = 2'b00; bus.req0_valid = 1;
        bus.req1_data = 4'hC; bus.req1_amt = 4'd1; bus.req1_op = 2'b01; bus.req1_valid = 1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            wait_cycles(1);
            if (grants.size() >= 4) begin
                got = 1;
                break;
            end
        end
        chk("arb_four_grants", got, 1);
        if (got) begin
            chk("arb_grant0", grants[0], 0);
            chk("arb_grant1", grants[1], 1);
            chk("arb_grant2", grants[2], 0);
            chk("arb_grant3", grants[3], 1);
        end
        idle_inputs();
        wait_cycles(20);

        // Backpressure: result held, no grants, next grant right after release.
        bus.resp_ready = 0;
        bus.req0_data = 4'h9; bus.req0_amt = 4'd1; bus.req0_op = 2'b00; bus.req0_valid = 1;
        bus.req1_data = 4'h6; bus.req1_amt = 4'd2; bus.req1_op = 2'b01; bus.req1_valid = 1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            wait_cycles(1);
            if (bus.resp_valid) begin
                got = 1;
                break;
            end
        end
        chk("bp_resp_seen", got, 1);
        d0 = bus.resp_data;
        i0 = bus.resp_id;
        chk("bp_first_data", d0, i0 ? 4'h8 : 4'h4);
        for (int k = 0; k < 3; k++) begin
            wait_cycles(1);
            chk("bp_hold_valid", bus.resp_valid, 1);
            chk("bp_hold_data", bus.resp_data, d0);
            chk("bp_hold_id", bus.resp_id, i0);
            chk("bp_hold_ready", {bus.req1_ready, bus.req0_ready}, 0);
        end
        bus.resp_ready = 1;
        wait_cycles(1);
        chk("bp_valid_drop", bus.resp_valid, 0);
        chk("bp_next_grant_other", i0 ? bus.req0_ready : bus.req1_ready, 1);
        chk("bp_next_grant_served", i0 ? bus.req1_ready : bus.req0_ready, 0);
        wait_cycles(1);
        idle_inputs();
        wait_cycles(20);

        // Asynchronous reset in the middle of a long shift.
        send_start_lsr4();
        wait_cycles(1);
        bus.req0_valid = 1; bus.req1_valid = 1;
        #2;
        rst_n = 0;
        #1;
        chk("midrst_resp_valid", bus.resp_valid, 0);
        chk("midrst_resp_data", bus.resp_data, 0);
        chk("midrst_resp_id", bus.resp_id, 0);
        wait_cycles(2);
        rst_n = 1;
        @(negedge clk);
        chk("midrst_first_req0", bus.req0_ready, 1);
        chk("midrst_first_req1", bus.req1_ready, 0);
        chk("midrst_no_resp", bus.resp_valid, 0);
        wait_cycles(1);
        idle_inputs();
        wait_cycles(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    // Launch LSR 4'hF by 4 on requester 0 and return just after its grant edge.
    task automatic send_start_lsr4();
        bit got;
        bus.req0_data = 4'hF; bus.req0_amt = 4'd4; bus.req0_op = 2'b00; bus.req0_valid = 1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                got = 1;
                break;
            end
        end
        chk("midrst_grant", got, 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule

// File: doc/shift_arb_seq.md
Name: shift_arb_seq

Overview:
- Shares one bit-serial shift datapath between two requesters.
- Each request carries an operand, a shift amount and an op code. Requests are granted round-robin.
- The block shifts the captured operand one bit per cycle, then holds the result on a valid/ready response port.
- Its logical-right result must match the combinational `>>` operator for every operand/amount pair, including amounts ≥ WIDTH.

Parameters:
- WIDTH, 4, operand/result width in bits.
- SHW, 4, shift-amount width; amounts 0 .. 2^SHW-1 are legal.
- CW, 3, shift counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  WIDTH  requester 0 operand.
- req0_amt  in  SHW  requester 0 shift amount.
- req0_op  in  2  requester 0 op: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
- req1_valid, req1_ready, req1_data, req1_amt, req1_op: same meanings for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  WIDTH  shifted result.
- resp_id  out  1  requester index the result belongs to.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, resp_valid=0, resp_data=0, resp_id=0, req0_ready=req1_ready=0, priority pointer=0.
- States: IDLE, SHIFT, DONE.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester selected by the priority pointer.
  - reqN_ready is combinational and high only in IDLE, only for the granted N, for exactly one cycle.
  - The handshake completes when valid and ready are both high at the clock edge.
- On grant, capture data, op and id. Load the counter cnt:
  - ROR: amt mod WIDTH.
  - LSR, LSL, ASR: min(amt, WIDTH).
  - Next state is SHIFT.
- SHIFT:
  - If cnt==0, go to DONE and assert resp_valid.
  - Otherwise apply a one-bit step to the working register and decrement cnt.
  - LSR shifts in 0 at the MSB. LSL shifts in 0 at the LSB. ASR replicates the MSB. ROR moves the LSB to the MSB.
- Latency: handshake at edge T; resp_valid rises at edge T+1+n, where n is the loaded cnt. amt=0 gives resp_valid at T+1 with data unchanged.
- DONE:
  - resp_valid=1; resp_data and resp_id are held stable until the resp_valid && resp_ready edge.
  - At that edge: resp_valid drops, the pointer is set to the other requester, and state returns to IDLE.
  - No grant is issued in the same cycle as the response handshake. The earliest next grant is the following cycle.
- No request is accepted in SHIFT or DONE. reqN_ready=0 there regardless of valid.
- Requester inputs are sampled only at the grant edge. Changes to them afterwards do not affect the in-flight operation.
- Results for amt ≥ WIDTH:
  - LSR and LSL give 0.
  - ASR gives all bits equal to the operand MSB.
  - ROR uses amt mod WIDTH.
- resp_ready high while resp_valid is low is ignored.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The in-flight request is dropped and no response is issued. The pointer returns to 0.
- A dropped request is not re-issued automatically. The requester must present it again.

Test Plan:
- Exhaustive LSR sweep, WIDTH=4: req0 only, all 16×16 data/amt pairs with resp_ready=1 -> every resp_data equals data>>amt (e.g. 4'hA,amt 1 -> 4'h5 at T+2; amt 9 -> 4'h0 at T+5).
- Op coverage:
  - ASR 4'b1000 amt 2 -> 4'b1110 at T+3.
  - LSL 4'b0011 amt 3 -> 4'b1000.
  - ROR 4'b0001 amt 5 -> 4'b1000 at T+2.
  - amt 0 on any op -> data unchanged at T+1.
- Arbitration: req0 and req1 both valid continuously with different data -> grants alternate 0,1,0,1. resp_id matches each result. No grant while busy.
- Backpressure: hold resp_ready=0 for 3 cycles in DONE -> resp_valid/resp_data/resp_id stable. reqN_ready stays 0. The next grant comes 1 cycle after the resp handshake.
- Reset mid-SHIFT: rst_n low during an amt=4 LSR -> outputs clear immediately. No resp_valid after release. Pointer is back to 0: with both requesters valid, req0 is granted first.
